// File: rtl/clk_divider_any.sv
// Programmable clock divider for any N in 1..2^WIDTH-1 with glitch-free factor changes.
// Optional CLK_DIVIDER_ODD_50_DUTY_EN adds a negedge stage giving 50% duty for odd N >= 3.
module clk_divider_any #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] N,
    output logic             out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] n_active
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             start;
    logic             last;

    // Number of posedge-registered high cycles; ceil form cannot overflow for n = 2^WIDTH-1.
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
`ifdef CLK_DIVIDER_ODD_50_DUTY_EN
        // Odd n >= 3 uses floor; the negedge stage supplies the extra half cycle.
        if (n[0] && (n != WIDTH'(1))) begin
            return n >> 1;
        end
`endif
        return (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
    endfunction

    assign start = enable && (N != '0);
    assign last  = (cnt_q == (n_q - WIDTH'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                out_d = 1'b0;
                if (start) begin
                    state_d = StRun;
                    n_d     = N;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            StRun: begin
                if (last) begin
                    cnt_d = '0;
                    if (start) begin
                        n_d    = N;
                        out_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        out_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    out_d = (cnt_d < high_len(n_q));
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            n_q     <= '0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CLK_DIVIDER_ODD_50_DUTY_EN
    logic dly_q;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= out_q;
        end
    end

    assign out = out_q | (dly_q & n_q[0] & (n_q != WIDTH'(1)));
`else
    assign out = out_q;
`endif

    assign tick     = tick_q;
    assign busy     = (state_q == StRun);
    assign n_active = n_q;

endmodule

// File: doc/clk_divider_any.md
Name: clk_divider_any

Overview:
- Programmable clock divider; successor to the even-only divider.
- Divides clk by any integer N in 1..2^WIDTH-1, even or odd.
- N changes are applied glitch-free, only at period boundaries.
- Provides a divided clock, a one-cycle tick usable as a clock-enable, and status outputs. Sits in the clocking/timing section of the homework SoC.

Parameters:
WIDTH, 8, bit width of the divide factor N and the internal period counter

Ports:
clk       input   1      fast source clock
reset_n   input   1      asynchronous reset, active-low
enable    input   1      run request; sampled on clk rising edge
N         input   WIDTH  requested divide factor; 0 = stop
out       output  1      divided clock, registered
tick      output  1      one-clk pulse in the cycle out rises
busy      output  1      high while the divider is running
n_active  output  WIDTH  divide factor currently in use

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0, all state and outputs are cleared: out=0, tick=0, busy=0, n_active=0, cnt=0, state IDLE.
- States:
  - IDLE: out=0, tick=0, busy=0.
  - RUN: busy=1.
- IDLE->RUN: at a clk edge with enable=1 and N!=0.
  - n_active<=N, cnt<=0, out<=1, tick<=1.
  - out rises 1 clk after enable is first sampled high.
- RUN counting: cnt counts 0..n_active-1, then wraps to 0.
  - out=1 when cnt < ceil(n_active/2), else 0.
  - tick=1 only when cnt=0.
  - Period = n_active clks; high phase = ceil(n_active/2) clks; low phase = floor(n_active/2) clks.
- Period boundary: the edge where cnt=n_active-1. All changes are applied only here:
  - if enable=1 and N!=0: n_active<=N, cnt<=0; next period starts with the new factor.
  - if enable=0 or N=0: go to IDLE; out stays 0.
  - The current period always completes, so out never shows a runt pulse.
- N changes mid-period: ignored until the boundary. Only the N value present at the boundary edge is used.
- enable toggling mid-period (0 then back to 1 before the boundary): no effect.
- n_active=1: boundary occurs every cycle. out=1 and tick=1 continuously while running. Stop takes effect on the next edge.
- Arithmetic:
  - cnt is WIDTH bits.
  - ceil computed as (n_active>>1) + n_active[0], with no overflow for n_active=2^WIDTH-1.
- Reset mid-period: immediate return to the reset state. Restart follows the normal IDLE->RUN rule.
- All outputs are driven from registers only, except the optional feature below.

Optional Feature:
- Macro: CLK_DIVIDER_ODD_50_DUTY_EN.
- When defined:
  - Adds a negedge-clk register that delays the posedge out by half a clk.
  - For odd n_active>=3, final out = posedge_out OR delayed_out.
  - High phase becomes (n_active-1)/2 + 0.5 clks, i.e. exactly 50% duty.
  - Even n_active, n_active=1, tick, busy and all state-transition timing are unchanged.
  - The delay register is also cleared by reset_n.
- When undefined: no negedge logic; odd N gives a ceil/floor duty cycle as described in Behaviour.

Test Plan:
- Reset then enable=1, N=4 -> out rises 1 clk after enable; out pattern 1100 repeating; tick every 4 clks; n_active=4.
- N=5, macro undefined -> out high 3 clks, low 2 clks; tick period 5. Macro defined -> out high 2.5 clks (measure 50% duty), period 5 clks.
- Running N=6, change N to 3 at cnt=2 -> current period finishes as 111000; next periods are 110; n_active updates on the boundary edge only.
- Running N=8, drop enable at cnt=1 -> period completes (4 high, 4 low); busy=0 and out=0 after the boundary; no further ticks. Also set N=0 while enable=1 -> same stop behaviour.
- N=1 with enable=1 -> out=1 and tick=1 every cycle; enable=0 -> out=0 and busy=0 one edge later.
- Assert reset_n=0 asynchronously mid-high-phase with N=255 -> out, tick, busy and n_active go to 0 immediately, without a clk edge. Release reset with enable=1 -> restart, first tick 1 clk later, 128-high/127-low pattern.
